// File: rtl/mem_sweep_checker.sv
// Read-side sweep engine: walks a wrapping address window of a 1-cycle-latency RAM
// and folds each word into a 32-bit rotate-left/XOR signature compared against a golden value.
module mem_sweep_checker #(
  parameter int WID_MEM   = 36,
  parameter int DEPTH_MEM = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        sweep_base,
  input  logic [31:0]        sweep_len,
  input  logic [31:0]        golden,
  output logic [31:0]        raddr,
  input  logic [WID_MEM-1:0] dout,
  output logic               busy,
  output logic               done,
  output logic [31:0]        signature,
  output logic               match,
  output logic [31:0]        words_read,
  output logic [1:0]         fsm_state
);

  // Handshake: start is a single-cycle request honoured only in IDLE (abort has priority);
  // done is a single-cycle completion strobe and the result outputs are stable while it is high.

  localparam int          NSLICE = (WID_MEM + 31) / 32;
  localparam int          PADW   = NSLICE * 32;
  localparam logic [31:0] DEPTH  = 32'(DEPTH_MEM);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic        vld;
  logic [31:0] rem;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [31:0] count;
  logic [31:0] golden_q;

  function automatic logic [31:0] fold(input logic [WID_MEM-1:0] w);
    logic [PADW-1:0] p;
    logic [31:0]     r;
    p = PADW'(w);
    r = '0;
    for (int i = 0; i < NSLICE; i++) r = r ^ p[i*32 +: 32];
    return r;
  endfunction

  assign acc_next  = {acc[30:0], acc[31]} ^ fold(dout);
  assign busy      = (state == ISSUE) || (state == DRAIN);
  assign done      = (state == DONE);
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start && !abort) state_next = (sweep_len == 32'd0) ? DONE : ISSUE;
      ISSUE: if (abort) state_next = IDLE;
             else if (rem == 32'd1) state_next = DRAIN;
      DRAIN: state_next = abort ? IDLE : DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raddr      <= '0;
      vld        <= 1'b0;
      rem        <= '0;
      acc        <= '0;
      count      <= '0;
      golden_q   <= '0;
      signature  <= '0;
      match      <= 1'b0;
      words_read <= '0;
    end else begin
      // Data returns one cycle after its address, so the fold is gated by a delayed issue flag.
      vld <= (state == ISSUE) && !abort;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            golden_q <= golden;
            acc      <= '0;
            count    <= '0;
            rem      <= sweep_len;
            if (sweep_len == 32'd0) begin
              signature  <= '0;
              match      <= (golden == 32'd0);
              words_read <= '0;
            end else begin
              raddr <= sweep_base % DEPTH;
            end
          end
        end
        ISSUE: begin
          if (!abort) begin
            rem <= rem - 32'd1;
            // The final issued address is held so raddr reflects the last word read.
            if (rem != 32'd1) raddr <= (raddr == DEPTH - 32'd1) ? 32'd0 : raddr + 32'd1;
            if (vld) begin
              acc   <= acc_next;
              count <= count + 32'd1;
            end
          end
        end
        DRAIN: begin
          if (!abort) begin
            acc        <= acc_next;
            count      <= count + 32'd1;
            signature  <= acc_next;
            match      <= (acc_next == golden_q);
            words_read <= count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sweep_checker.sv
// Directed and randomized checks of mem_sweep_checker against a behavioural RAM and
// a signature model computed straight from the rotate/XOR folding rule.
module tb_mem_sweep_checker;
  localparam int W = 36;
  localparam int D = 512;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [31:0]  sweep_base, sweep_len, golden;
  logic [31:0]  raddr;
  logic [W-1:0] dout;
  logic         busy, done, match;
  logic [31:0]  signature, words_read;
  logic [1:0]   fsm_state;

  logic [W-1:0] mem [D];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] last_sig;
  logic [31:0] last_wr;
  logic        last_match;

  always #5 clk = ~clk;

  mem_sweep_checker #(.WID_MEM(W), .DEPTH_MEM(D)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sweep_base(sweep_base), .sweep_len(sweep_len), .golden(golden),
    .raddr(raddr), .dout(dout), .busy(busy), .done(done),
    .signature(signature), .match(match), .words_read(words_read),
    .fsm_state(fsm_state)
  );

  always @(posedge clk) dout <= mem[int'(raddr % 32'(D))];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_sig(input int unsigned base, input int unsigned len);
    logic [31:0] s;
    logic [W-1:0] w;
    s = 32'd0;
    for (int unsigned i = 0; i < len; i++) begin
      w = mem[(base + i) % D];
      s = {s[30:0], s[31]} ^ (w[31:0] ^ {28'd0, w[35:32]});
    end
    return s;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < D; i++) mem[i] = '0;
  endtask

  task automatic random_mem();
    for (int i = 0; i < D; i++) mem[i] = {4'($urandom()), 32'($urandom())};
  endtask

  task automatic run_sweep(input int unsigned base, input int unsigned len,
                           input logic [31:0] gold, input string tag);
    logic [31:0] exp_sig;
    int unsigned c;
    int unsigned exp_lat;
    exp_sig = model_sig(base, len);
    exp_lat = (len == 0) ? 1 : len + 2;
    sweep_base = base;
    sweep_len  = len;
    golden     = gold;
    start      = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    if (len > 0) chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    while (!done && c < exp_lat + 8) begin
      if (c <= len && c <= 8) chk({tag, " raddr"}, raddr, (base + c - 1) % D);
      step();
      c++;
    end
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " latency"}, c, exp_lat);
    chk({tag, " signature"}, signature, exp_sig);
    chk({tag, " match"}, {31'd0, match}, {31'd0, exp_sig == gold});
    chk({tag, " words_read"}, words_read, len);
    last_sig   = exp_sig;
    last_wr    = len;
    last_match = (exp_sig == gold);
    step();
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] prev_raddr;
    int unsigned b, l;
    int          done_cnt;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    sweep_base = '0; sweep_len = '0; golden = '0;
    clear_mem();
    step(); step();
    chk("rst raddr", raddr, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst signature", signature, 32'd0);
    chk("rst match", {31'd0, match}, 32'd0);
    chk("rst words_read", words_read, 32'd0);
    reset = 1'b0;
    step();

    run_sweep(0, 512, 32'd0, "zeros");
    chk("zeros const sig", signature, 32'h0000_0000);

    mem[0] = 36'd1;
    run_sweep(0, 512, 32'h8000_0000, "one_hot");
    chk("one_hot const sig", signature, 32'h8000_0000);
    chk("one_hot const match", {31'd0, match}, 32'd1);
    run_sweep(0, 512, 32'h0000_0001, "one_hot_nomatch");
    chk("one_hot nomatch", {31'd0, match}, 32'd0);

    mem[0] = 36'hF_0000_0000;
    run_sweep(0, 1, 32'h0000_000F, "upper_fold");
    chk("upper_fold const sig", signature, 32'h0000_000F);

    random_mem();
    run_sweep(510, 4, $urandom(), "wrap");

    prev_raddr = raddr;
    run_sweep(37, 0, 32'd0, "len0");
    chk("len0 raddr held", raddr, prev_raddr);

    for (int k = 0; k < 8; k++) begin
      b = $urandom_range(0, 2047);
      l = $urandom_range(1, 40);
      if ($urandom_range(0, 1) == 1) run_sweep(b, l, model_sig(b, l), "rand_match");
      else                           run_sweep(b, l, $urandom(), "rand");
    end
    b = $urandom_range(0, 511);
    run_sweep(b, 600, model_sig(b, 600), "long_wrap");

    // Abort five cycles into a long sweep: results must stay at the previous sweep's values.
    sweep_base = 32'd3; sweep_len = 32'd100; golden = 32'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 110; k++) begin
      if (done) done_cnt++;
      step();
    end
    chk("abort no done", done_cnt, 32'd0);
    chk("abort sig held", signature, last_sig);
    chk("abort wr held", words_read, last_wr);
    chk("abort match held", {31'd0, match}, {31'd0, last_match});

    // A second start during a sweep must not disturb it.
    sweep_base = 32'd100; sweep_len = 32'd10; golden = 32'd0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    sweep_base = 32'd200; sweep_len = 32'd20;
    start = 1'b1; step(); start = 1'b0;
    done_cnt = 4;
    while (!done && done_cnt < 30) begin
      step();
      done_cnt++;
    end
    chk("restart latency", done_cnt, 32'd12);
    chk("restart sig", signature, model_sig(100, 10));
    chk("restart wr", words_read, 32'd10);
    step();

    // Start and abort together in IDLE: abort wins.
    sweep_base = 32'd5; sweep_len = 32'd3;
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start_abort busy", {31'd0, busy}, 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) done_cnt++;
      step();
    end
    chk("start_abort no done", done_cnt, 32'd0);

    // Reset in the middle of a sweep.
    sweep_base = 32'd7; sweep_len = 32'd50;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    reset = 1'b1; step();
    chk("midrst raddr", raddr, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst signature", signature, 32'd0);
    chk("midrst match", {31'd0, match}, 32'd0);
    chk("midrst words_read", words_read, 32'd0);
    reset = 1'b0;
    step();
    run_sweep(20, 5, 32'd0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_sweep_checker.md
Name: mem_sweep_checker

Overview:
Read-side sweep engine that sits directly downstream of the block-RAM memory instance: drives its read address, consumes its 1-cycle-latency read data, and folds a contiguous address window into a 32-bit rotating-XOR signature. Used after a bitstream memory re-initialisation to confirm RAM contents match a golden signature without reading back the whole device. Read port only; the memory's write port is outside this block's scope.

Parameters:
WID_MEM, 36, data width of the memory word being checked
DEPTH_MEM, 512, number of words in the memory; addresses wrap modulo DEPTH_MEM

Ports:
clk  input  1  single clock, shared with the memory
reset  input  1  synchronous, active-high
start  input  1  one-cycle pulse; begins a sweep when idle
abort  input  1  returns to IDLE next cycle; results are not updated
sweep_base  input  32  first address; sampled on start
sweep_len  input  32  number of words; sampled on start
golden  input  32  expected signature; sampled on start
raddr  output  32  read address to the memory
dout  input  WID_MEM  read data from the memory (valid 1 cycle after raddr)
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the signature is final
signature  output  32  final signature, held until the next accepted start
match  output  1  signature == golden latched at done, held
words_read  output  32  number of words folded in the last completed sweep

Behaviour:
- Reset: state IDLE; raddr=0, busy=0, done=0, signature=0, match=0, words_read=0, internal accumulator=0.
- fold(w): zero-pad w to ceil(WID_MEM/32)*32 bits, XOR all 32-bit slices together (WID_MEM=36: w[31:0] ^ {28'b0, w[35:32]}).
- Update per consumed word: acc <= rotl(acc,1) ^ fold(dout).
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 latches base/len/golden, clears acc and counters. If len=0: go straight to DONE (signature=0, words_read=0). Otherwise go to ISSUE with raddr=base mod DEPTH_MEM.
- ISSUE: one address per cycle; raddr increments by 1 and wraps from DEPTH_MEM-1 to 0. A "data valid" flag delayed 1 cycle from each issued address gates the fold. After len addresses have been issued, go to DRAIN.
- DRAIN: fold the final word, then go to DONE.
- DONE: signature<=acc, match<=(acc==golden_latched), words_read<=count; done=1 for exactly one cycle; next state IDLE.
- Latency: for len=N, done asserts N+2 cycles after the start cycle.
- start while busy: ignored. start and abort in the same IDLE cycle: abort wins, no sweep.
- abort in ISSUE/DRAIN: IDLE on the next cycle, busy=0, no done pulse; signature/match/words_read keep their previous values.
- reset mid-sweep: every output returns to its reset value on the next edge.
- len > DEPTH_MEM: addresses keep wrapping and words are re-read; this is legal.
- raddr holds its last value while in IDLE.
- The counter and length arithmetic are 32-bit unsigned; sweep_len=0xFFFFFFFF is legal (long sweep).

Test Plan:
- Memory all zeros, base=0, len=512, golden=0 -> done at cycle start+514, signature=0x00000000, match=1, words_read=512.
- mem[0]=1, all others 0, base=0, len=512 -> signature=0x80000000 (rotl(1,511)); golden=0x80000000 gives match=1, golden=1 gives match=0.
- mem[0]=36'hF_0000_0000, all others 0, base=0, len=1 -> signature=0x0000000F, done 3 cycles after start.
- base=510, len=4 -> raddr sequence 510, 511, 0, 1; words_read=4; signature equals the software model over those four words.
- len=0 -> done 1 cycle after start, signature=0, words_read=0, raddr unchanged.
- abort 5 cycles into a len=100 sweep -> busy drops the next cycle, no done pulse, previous signature held. A second start during a sweep is ignored. reset mid-sweep -> all outputs return to 0.
